// File: rtl/inst_queue_if.sv
// inst_queue_if: fetch-side write, scheduler-side issue and lookahead signals of the instruction queue
interface inst_queue_if #(
  parameter int PTR_W = 3
);
  logic             wr_en;
  logic [31:0]      wr_inst;
  logic             full;
  logic             empty;
  logic             issue_en;
  logic             sel_inst;
  logic [31:0]      issue_inst;
  logic             issue_valid;
  logic [PTR_W-1:0] read;
  logic [5:0]       opcode;
  logic [4:0]       rd1_q;
  logic [4:0]       rd2_q;
  logic [4:0]       rs_next_q;
  logic [4:0]       rt_next_q;
  modport master (
    output wr_en, wr_inst, issue_en, sel_inst,
    input  full, empty, issue_inst, issue_valid, read, opcode, rd1_q, rd2_q, rs_next_q, rt_next_q
  );
  modport slave (
    input  wr_en, wr_inst, issue_en, sel_inst,
    output full, empty, issue_inst, issue_valid, read, opcode, rd1_q, rd2_q, rs_next_q, rt_next_q
  );
endinterface

// File: rtl/inst_queue.sv
// inst_queue: circular instruction queue with head/next lookahead decode and one-slot reorder issue
module inst_queue #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input logic        clk,
  input logic        reset,
  inst_queue_if.slave q
);
  logic [31:0]      mem [DEPTH];
  logic [PTR_W-1:0] head, tail, nxt;
  logic [PTR_W:0]   count, occ;
  logic             skip, has1, has2, do_write, do_issue, reorder;
  logic [31:0]      hd_inst, nx_inst;
  function automatic logic [4:0] dest(input logic [31:0] i);
    return i[31:26] == 6'd0 ? i[15:11] : i[20:16];
  endfunction
  always_comb begin
    occ         = count + (PTR_W+1)'(skip);
    nxt         = skip ? head + PTR_W'(2) : head + PTR_W'(1);
    has1        = count != '0;
    has2        = count >= (PTR_W+1)'(2);
    hd_inst     = has1 ? mem[head] : 32'd0;
    nx_inst     = has2 ? mem[nxt] : 32'd0;
    q.full      = occ == (PTR_W+1)'(DEPTH);
    q.empty     = !has1;
    q.read      = head;
    q.opcode    = hd_inst[31:26];
    q.rd1_q     = dest(hd_inst);
    q.rd2_q     = dest(nx_inst);
    q.rs_next_q = nx_inst[25:21];
    q.rt_next_q = nx_inst[20:16];
    do_write    = q.wr_en && !q.full;
    do_issue    = q.issue_en && has1;
    reorder     = !skip && q.sel_inst && has2;
  end
  always_ff @(posedge clk)
    if (do_write) mem[tail] <= q.wr_inst;
  always_ff @(posedge clk) begin
    if (reset) begin
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      skip          <= 1'b0;
      q.issue_valid <= 1'b0;
      q.issue_inst  <= 32'd0;
    end else begin
      q.issue_valid <= do_issue;
      count         <= count + (PTR_W+1)'(do_write) - (PTR_W+1)'(do_issue);
      if (do_write) tail <= tail + PTR_W'(1);
      if (do_issue) begin
        q.issue_inst <= reorder ? mem[nxt] : mem[head];
        head         <= skip ? head + PTR_W'(2) : reorder ? head : head + PTR_W'(1);
        skip         <= reorder;
      end
    end
  end
endmodule

// File: tb/tb_inst_queue.sv
// tb_inst_queue: randomized and directed checks of inst_queue against a logical-queue reference model
module tb_inst_queue;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  inst_queue_if #(.PTR_W(3)) q ();
  inst_queue #(.DEPTH(8), .PTR_W(3)) dut (.clk(clk), .reset(reset), .q(q.slave));
  always #5 clk = ~clk;
  logic [31:0] pend[$];
  bit          skipped;
  int          released;
  logic        exp_valid;
  logic [31:0] exp_inst;
  function automatic logic [4:0] dst(input logic [31:0] i);
    return i[31:26] == 6'd0 ? i[15:11] : i[20:16];
  endfunction
  function automatic int mcnt();
    return pend.size() - int'(skipped);
  endfunction
  function automatic logic [31:0] mhead();
    return mcnt() >= 1 ? pend[0] : 32'd0;
  endfunction
  function automatic logic [31:0] mnext();
    return mcnt() >= 2 ? pend[skipped ? 2 : 1] : 32'd0;
  endfunction
  task automatic drive(input bit w, input logic [31:0] d, input bit ie, input bit sel);
    bit do_write;
    q.wr_en = w;
    q.wr_inst = d;
    q.issue_en = ie;
    q.sel_inst = sel;
    do_write = w && pend.size() < 8;
    exp_valid = ie && mcnt() >= 1;
    if (exp_valid) begin
      if (skipped) begin
        exp_inst = pend[0];
        pend.delete(0);
        pend.delete(0);
        released += 2;
        skipped = 0;
      end else if (sel && mcnt() >= 2) begin
        exp_inst = pend[1];
        skipped = 1;
      end else begin
        exp_inst = pend[0];
        pend.delete(0);
        released += 1;
      end
    end
    if (do_write) pend.push_back(d);
    @(posedge clk);
    #1;
    q.wr_en = 1'b0;
    q.issue_en = 1'b0;
    q.sel_inst = 1'b0;
  endtask
  task automatic do_reset();
    q.wr_en = 1'b0;
    q.issue_en = 1'b0;
    q.sel_inst = 1'b0;
    q.wr_inst = 32'd0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    pend.delete();
    skipped = 0;
    released = 0;
    exp_valid = 1'b0;
    exp_inst = 32'd0;
  endtask
  task automatic test_reset();
    do_reset();
    checks++; if (q.full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", q.full); end
    checks++; if (q.empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", q.empty); end
    checks++; if (q.read !== 3'd0) begin failures++; $display("FAIL reset_read got=%0d exp=0", q.read); end
    checks++; if (q.issue_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", q.issue_valid); end
    checks++; if (q.issue_inst !== 32'd0) begin failures++; $display("FAIL reset_inst got=%h exp=0", q.issue_inst); end
    checks++; if ({q.opcode, q.rd1_q, q.rd2_q, q.rs_next_q, q.rt_next_q} !== 26'd0) begin failures++; $display("FAIL reset_fields got=%h exp=0", {q.opcode, q.rd1_q, q.rd2_q, q.rs_next_q, q.rt_next_q}); end
  endtask
  task automatic test_inorder();
    logic [31:0] iv [3] = '{32'h8C250000, 32'h00A23020, 32'h20430004};
    do_reset();
    for (int i = 0; i < 3; i++) drive(1, iv[i], 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 0);
      checks++; if (q.issue_valid !== 1'b1 || q.issue_inst !== iv[i]) begin failures++; $display("FAIL inorder_inst%0d got=%b/%h exp=1/%h", i, q.issue_valid, q.issue_inst, iv[i]); end
      checks++; if (q.read !== 3'(i + 1)) begin failures++; $display("FAIL inorder_read%0d got=%0d exp=%0d", i, q.read, i + 1); end
      checks++; if (q.empty !== (i == 2)) begin failures++; $display("FAIL inorder_empty%0d got=%b exp=%b", i, q.empty, i == 2); end
    end
    drive(0, 0, 0, 0);
    checks++; if (q.issue_valid !== 1'b0 || q.issue_inst !== iv[2]) begin failures++; $display("FAIL valid_pulse got=%b/%h exp=0/%h", q.issue_valid, q.issue_inst, iv[2]); end
    drive(0, 0, 1, 0);
    checks++; if (q.issue_valid !== 1'b0 || q.issue_inst !== iv[2]) begin failures++; $display("FAIL issue_empty got=%b/%h exp=0/%h", q.issue_valid, q.issue_inst, iv[2]); end
  endtask
  task automatic test_decode();
    do_reset();
    drive(1, 32'h8C250000, 0, 0);
    drive(1, 32'h00A23020, 0, 0);
    checks++; if (q.opcode !== 6'h23) begin failures++; $display("FAIL dec_opcode got=%h exp=23", q.opcode); end
    checks++; if (q.rd1_q !== 5'd5) begin failures++; $display("FAIL dec_rd1 got=%0d exp=5", q.rd1_q); end
    checks++; if (q.rs_next_q !== 5'd5) begin failures++; $display("FAIL dec_rs_next got=%0d exp=5", q.rs_next_q); end
    checks++; if (q.rt_next_q !== 5'd2) begin failures++; $display("FAIL dec_rt_next got=%0d exp=2", q.rt_next_q); end
    checks++; if (q.rd2_q !== 5'd6) begin failures++; $display("FAIL dec_rd2 got=%0d exp=6", q.rd2_q); end
  endtask
  task automatic test_reorder();
    logic [31:0] a = 32'h8C250000, b = 32'h20430004, c = 32'h00E84820;
    do_reset();
    drive(1, a, 0, 0);
    drive(1, b, 0, 0);
    drive(1, c, 0, 0);
    drive(0, 0, 1, 1);
    checks++; if (q.issue_inst !== b || q.read !== 3'd0) begin failures++; $display("FAIL reorder_b got=%h/%0d exp=%h/0", q.issue_inst, q.read, b); end
    checks++; if (q.rs_next_q !== 5'd7 || q.rt_next_q !== 5'd8 || q.rd2_q !== 5'd9 || q.rd1_q !== 5'd5) begin failures++; $display("FAIL reorder_next got=%0d/%0d/%0d/%0d exp=7/8/9/5", q.rs_next_q, q.rt_next_q, q.rd2_q, q.rd1_q); end
    drive(0, 0, 1, 1);
    checks++; if (q.issue_inst !== a || q.read !== 3'd2) begin failures++; $display("FAIL reorder_a got=%h/%0d exp=%h/2", q.issue_inst, q.read, a); end
    drive(0, 0, 1, 0);
    checks++; if (q.issue_inst !== c || q.read !== 3'd3 || q.empty !== 1'b1) begin failures++; $display("FAIL reorder_c got=%h/%0d/%b exp=%h/3/1", q.issue_inst, q.read, q.empty, c); end
  endtask
  task automatic test_full_wrap();
    logic [31:0] e [9];
    do_reset();
    for (int i = 0; i < 9; i++) e[i] = $urandom();
    for (int i = 0; i < 8; i++) drive(1, e[i], 0, 0);
    checks++; if (q.full !== 1'b1) begin failures++; $display("FAIL full_set got=%b exp=1", q.full); end
    drive(1, 32'hDEADBEEF, 1, 0);
    checks++; if (q.issue_inst !== e[0] || q.full !== 1'b0) begin failures++; $display("FAIL full_refuse got=%h/%b exp=%h/0", q.issue_inst, q.full, e[0]); end
    drive(1, e[8], 0, 0);
    checks++; if (q.full !== 1'b1) begin failures++; $display("FAIL full_wrap got=%b exp=1", q.full); end
    for (int i = 1; i < 9; i++) begin
      drive(0, 0, 1, 0);
      checks++; if (q.issue_inst !== e[i]) begin failures++; $display("FAIL wrap_order%0d got=%h exp=%h", i, q.issue_inst, e[i]); end
    end
    checks++; if (q.empty !== 1'b1 || q.read !== 3'd1) begin failures++; $display("FAIL wrap_end got=%b/%0d exp=1/1", q.empty, q.read); end
  endtask
  task automatic test_sel_count1();
    do_reset();
    drive(1, 32'h11111111, 0, 0);
    drive(0, 0, 1, 1);
    checks++; if (q.issue_inst !== 32'h11111111 || q.read !== 3'd1 || q.empty !== 1'b1) begin failures++; $display("FAIL sel1_issue got=%h/%0d/%b exp=11111111/1/1", q.issue_inst, q.read, q.empty); end
    drive(1, 32'h22222222, 0, 0);
    drive(1, 32'h33333333, 0, 0);
    drive(0, 0, 1, 0);
    checks++; if (q.issue_inst !== 32'h22222222 || q.read !== 3'd2) begin failures++; $display("FAIL sel1_noskip got=%h/%0d exp=22222222/2", q.issue_inst, q.read); end
  endtask
  task automatic test_reset_skip();
    do_reset();
    for (int i = 0; i < 3; i++) drive(1, 32'h8C250000 + 32'(i), 0, 0);
    drive(0, 0, 1, 1);
    do_reset();
    checks++; if (q.issue_valid !== 1'b0 || q.issue_inst !== 32'd0 || q.read !== 3'd0 || q.empty !== 1'b1 || q.full !== 1'b0) begin failures++; $display("FAIL rst_skip_ctl got=%b/%h/%0d/%b/%b exp=0/0/0/1/0", q.issue_valid, q.issue_inst, q.read, q.empty, q.full); end
    checks++; if ({q.opcode, q.rd1_q, q.rd2_q, q.rs_next_q, q.rt_next_q} !== 26'd0) begin failures++; $display("FAIL rst_skip_fields got=%h exp=0", {q.opcode, q.rd1_q, q.rd2_q, q.rs_next_q, q.rt_next_q}); end
    drive(1, 32'hAAAA0001, 0, 0);
    drive(1, 32'hBBBB0002, 0, 0);
    drive(0, 0, 1, 0);
    checks++; if (q.issue_inst !== 32'hAAAA0001 || q.read !== 3'd1) begin failures++; $display("FAIL rst_skip_clear got=%h/%0d exp=aaaa0001/1", q.issue_inst, q.read); end
  endtask
  task automatic test_back_to_back();
    do_reset();
    drive(1, 32'h01000000, 1, 0);
    checks++; if (q.issue_valid !== 1'b0 || q.empty !== 1'b0) begin failures++; $display("FAIL nobypass got=%b/%b exp=0/0", q.issue_valid, q.empty); end
    drive(1, 32'h02000000, 0, 0);
    drive(1, 32'h03000000, 0, 0);
    drive(1, 32'h04000000, 1, 0);
    checks++; if (q.issue_inst !== 32'h01000000) begin failures++; $display("FAIL simul_inst got=%h exp=01000000", q.issue_inst); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (q.empty !== 1'b0) begin failures++; $display("FAIL simul_count%0d got=%b exp=0", i, q.empty); end
      drive(0, 0, 1, 0);
    end
    checks++; if (q.empty !== 1'b1 || q.issue_inst !== 32'h04000000) begin failures++; $display("FAIL simul_drain got=%b/%h exp=1/04000000", q.empty, q.issue_inst); end
  endtask
  task automatic test_random();
    logic [31:0] d, h, n;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      d = $urandom();
      if ($urandom_range(1) == 0) d[31:26] = 6'd0;
      drive($urandom_range(99) < 55, d, $urandom_range(99) < 50, $urandom_range(1) == 1);
      h = mhead();
      n = mnext();
      checks++; if (q.full !== (pend.size() == 8)) begin failures++; $display("FAIL rnd_full c=%0d got=%b exp=%b", c, q.full, pend.size() == 8); end
      checks++; if (q.empty !== (mcnt() == 0)) begin failures++; $display("FAIL rnd_empty c=%0d got=%b exp=%b", c, q.empty, mcnt() == 0); end
      checks++; if (q.issue_valid !== exp_valid) begin failures++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, q.issue_valid, exp_valid); end
      checks++; if (q.issue_inst !== exp_inst) begin failures++; $display("FAIL rnd_inst c=%0d got=%h exp=%h", c, q.issue_inst, exp_inst); end
      checks++; if (q.read !== 3'(released % 8)) begin failures++; $display("FAIL rnd_read c=%0d got=%0d exp=%0d", c, q.read, released % 8); end
      checks++; if (q.opcode !== h[31:26] || q.rd1_q !== dst(h)) begin failures++; $display("FAIL rnd_head c=%0d got=%h/%0d exp=%h/%0d", c, q.opcode, q.rd1_q, h[31:26], dst(h)); end
      checks++; if (q.rd2_q !== dst(n) || q.rs_next_q !== n[25:21] || q.rt_next_q !== n[20:16]) begin failures++; $display("FAIL rnd_next c=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", c, q.rd2_q, q.rs_next_q, q.rt_next_q, dst(n), n[25:21], n[20:16]); end
    end
  endtask
  initial begin
    q.wr_en = 1'b0;
    q.wr_inst = 32'd0;
    q.issue_en = 1'b0;
    q.sel_inst = 1'b0;
    test_reset();
    test_inorder();
    test_decode();
    test_reorder();
    test_full_wrap();
    test_sel_count1();
    test_reset_skip();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
